// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the pipeline datapath.
// master = datapath side, slave = controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             fwd_en;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             two_src;
  logic             id_valid;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             cnt_clr;
  logic             freeze_pc;
  logic             freeze_ifid;
  logic             flush_ifid;
  logic             freeze_idexe;
  logic             flush_idexe;
  logic             freeze_back;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output fwd_en, src1, src2, two_src, id_valid, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready, cnt_clr,
    input  freeze_pc, freeze_ifid, flush_ifid, freeze_idexe, flush_idexe, freeze_back,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  fwd_en, src1, src2, two_src, id_valid, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready, cnt_clr,
    output freeze_pc, freeze_ifid, flush_ifid, freeze_idexe, flush_idexe, freeze_back,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush sequencer for the 5-stage pipeline: RAW bubbles, branch flushes,
// data-memory wait freezes with timeout, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 256,
  parameter int unsigned CNT_W    = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_ctr_q, wait_ctr_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic s1_exe, s2_exe, s1_mem, s2_mem;
  logic raw_hz, timeout_now, mem_stall;
  logic frz_pc, frz_ifid, fl_ifid, frz_idexe, fl_idexe, frz_back, br_flush;

  assign s1_exe = (bus.src1 == bus.exe_dest);
  assign s2_exe = (bus.src2 == bus.exe_dest);
  assign s1_mem = (bus.src1 == bus.mem_dest);
  assign s2_mem = (bus.src2 == bus.mem_dest);

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    raw_hz = 1'b0;
    if (bus.id_valid) begin
      if (bus.fwd_en) begin
        raw_hz = bus.exe_mem_r_en & (s1_exe | (bus.two_src & s2_exe));
      end else begin
        raw_hz = (s1_exe & bus.exe_wb_en) | (s1_mem & bus.mem_wb_en) |
                 (bus.two_src & ((s2_exe & bus.exe_wb_en) | (s2_mem & bus.mem_wb_en)));
      end
    end
  end

  assign timeout_now = (state_q == MEM_WAIT) && (wait_ctr_q == WAIT_LAST);
  assign mem_stall   = bus.mem_req & ~bus.mem_ready & ~timeout_now;

  always_comb begin
    state_d    = state_q;
    wait_ctr_d = wait_ctr_q;
    timeout_d  = timeout_q;
    frz_pc     = 1'b0;
    frz_ifid   = 1'b0;
    fl_ifid    = 1'b0;
    frz_idexe  = 1'b0;
    fl_idexe   = 1'b0;
    frz_back   = 1'b0;
    br_flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          {frz_pc, frz_ifid, frz_idexe, frz_back} = 4'b1111;
          state_d    = MEM_WAIT;
          wait_ctr_d = WAIT_W'(1);
        end else if (bus.branch_taken) begin
          fl_ifid  = 1'b1;
          fl_idexe = 1'b1;
          br_flush = 1'b1;
        end else if (raw_hz) begin
          frz_pc   = 1'b1;
          frz_ifid = 1'b1;
          fl_idexe = 1'b1;
        end
      end
      MEM_WAIT: begin
        // EXE is frozen here, so a pending branch is re-seen once back in RUN.
        if (bus.mem_ready) begin
          state_d    = RUN;
          wait_ctr_d = '0;
        end else if (timeout_now) begin
          state_d    = RUN;
          wait_ctr_d = '0;
          timeout_d  = 1'b1;
        end else begin
          {frz_pc, frz_ifid, frz_idexe, frz_back} = 4'b1111;
          wait_ctr_d = wait_ctr_q + WAIT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    stall_d = stall_q;
    flush_d = flush_q;
    if (bus.cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (frz_pc && stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
      if (br_flush && flush_q != CNT_MAX) flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_ctr_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_ctr_q <= wait_ctr_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  // Controls are gated by reset so freezes drop the moment reset asserts.
  assign bus.freeze_pc    = rst_n & frz_pc;
  assign bus.freeze_ifid  = rst_n & frz_ifid;
  assign bus.flush_ifid   = rst_n & fl_ifid;
  assign bus.freeze_idexe = rst_n & frz_idexe;
  assign bus.flush_idexe  = rst_n & fl_idexe;
  assign bus.freeze_back  = rst_n & frz_back;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule
